uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with a 2-flop input synchronizer, mid-bit
//                sampling, a valid/ready output handshake, and one-cycle
//                frame-error and overrun-error pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int c_HALF  = CLKS_PER_BIT / 2;
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_M1  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    logic               r_sync1_q;
    logic               r_sync2_q;
    state_t             r_state_q,  w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [2:0]         r_idx_q,    w_idx_d;
    logic [7:0]         r_shift_q,  w_shift_d;
    logic [7:0]         r_data_q,   w_data_d;
    logic               r_valid_q,  w_valid_d;
    logic               r_ferr_q,   w_ferr_d;
    logic               r_ovr_q,    w_ovr_d;
    logic               w_byte_done;
    logic               w_accept;
    logic               w_rxs;

    assign w_rxs    = r_sync2_q;
    assign w_accept = r_valid_q & rx_ready;

    // Two-flop synchronizer; resets high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
        end else begin
            r_sync1_q <= rxd;
            r_sync2_q <= r_sync1_q;
        end
    end

    // Next-state, sampling and output-handshake logic
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_idx_d     = r_idx_q;
        w_shift_d   = r_shift_q;
        w_data_d    = r_data_q;
        w_valid_d   = r_valid_q;
        w_ferr_d    = 1'b0;
        w_ovr_d     = 1'b0;
        w_byte_done = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_cnt_d = '0;
                if (!w_rxs) begin
                    w_state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the start bit half a bit in, rejecting glitches
                if (r_cnt_q == c_HALF_M1) begin
                    w_cnt_d = '0;
                    if (!w_rxs) begin
                        w_state_d = S_DATA;
                        w_idx_d   = 3'd0;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_cnt_q == c_BIT_M1) begin
                    w_cnt_d            = '0;
                    w_shift_d[r_idx_q] = w_rxs;
                    w_idx_d            = r_idx_q + 3'd1;
                    if (r_idx_q == 3'd7) begin
                        w_state_d = S_STOP;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            S_STOP: begin
                if (r_cnt_q == c_BIT_M1) begin
                    w_cnt_d = '0;
                    if (w_rxs) begin
                        w_byte_done = 1'b1;
                        w_state_d   = S_IDLE;
                    end else begin
                        w_ferr_d  = 1'b1;
                        w_state_d = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line returns high so a break reports once
                if (w_rxs) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // A byte lands if the holding register is empty or being drained now
        if (w_byte_done) begin
            if (!r_valid_q || w_accept) begin
                w_data_d  = r_shift_q;
                w_valid_d = 1'b1;
            end else begin
                w_ovr_d = 1'b1;
            end
        end else if (w_accept) begin
            w_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= 3'd0;
            r_shift_q <= 8'h00;
            r_data_q  <= 8'h00;
            r_valid_q <= 1'b0;
            r_ferr_q  <= 1'b0;
            r_ovr_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_shift_q <= w_shift_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_ferr_q  <= w_ferr_d;
            r_ovr_q   <= w_ovr_d;
        end
    end

    assign rx_data     = r_data_q;
    assign rx_valid    = r_valid_q;
    assign frame_err   = r_ferr_q;
    assign overrun_err = r_ovr_q;
    assign busy        = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx, one instance at
//                16 clocks/bit and one at the 4 clocks/bit minimum.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_s, rxd_f;
    logic       ready_s, ready_f;
    logic [7:0] data_s, data_f;
    logic       valid_s, valid_f;
    logic       ferr_s, ferr_f;
    logic       ovr_s, ovr_f;
    logic       busy_s, busy_f;

    int checks = 0;
    int errors = 0;
    int fe_s = 0, ov_s = 0, rise_s = 0, used_s = 0, used_f = 0;
    logic prev_valid_s = 1'b0;
    logic [7:0] q_s[$];
    logic [7:0] q_f[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) u_dut_s (
        .clk(clk), .rst(rst), .rxd(rxd_s), .rx_data(data_s), .rx_valid(valid_s),
        .rx_ready(ready_s), .frame_err(ferr_s), .overrun_err(ovr_s), .busy(busy_s)
    );

    uart_rx #(.CLKS_PER_BIT(4)) u_dut_f (
        .clk(clk), .rst(rst), .rxd(rxd_f), .rx_data(data_f), .rx_valid(valid_f),
        .rx_ready(ready_f), .frame_err(ferr_f), .overrun_err(ovr_f), .busy(busy_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit fast, input logic v);
        if (fast) rxd_f = v;
        else      rxd_s = v;
    endtask

    // Serialize one 8N1 frame; the line is left at the stop-bit level
    task automatic send(input bit fast, input logic [7:0] b, input logic stop_bit);
        int c;
        c = fast ? 4 : 16;
        set_line(fast, 1'b0);
        wait_cycles(c);
        for (int i = 0; i < 8; i++) begin
            set_line(fast, b[i]);
            wait_cycles(c);
        end
        set_line(fast, stop_bit);
        wait_cycles(c);
    endtask

    // Scoreboard: every handshake pops the expected byte; pulses are tallied
    always @(negedge clk) begin
        if (valid_s && ready_s) begin
            used_s++;
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_slow unexpected byte observed 0x%0h expected none", data_s);
            end else begin
                logic [7:0] exp;
                exp = q_s.pop_front();
                checks++;
                assert (data_s === exp) else begin
                    errors++;
                    $error("FAIL sb_slow observed 0x%0h expected 0x%0h", data_s, exp);
                end
            end
        end
        if (valid_f && ready_f) begin
            used_f++;
            if (q_f.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_fast unexpected byte observed 0x%0h expected none", data_f);
            end else begin
                logic [7:0] exp;
                exp = q_f.pop_front();
                checks++;
                assert (data_f === exp) else begin
                    errors++;
                    $error("FAIL sb_fast observed 0x%0h expected 0x%0h", data_f, exp);
                end
            end
        end
        if (ferr_s) fe_s++;
        if (ovr_s)  ov_s++;
        if (valid_s && !prev_valid_s) rise_s++;
        prev_valid_s = valid_s;
    end

    initial begin
        int r0;
        rst = 1'b1; rxd_s = 1'b1; rxd_f = 1'b1; ready_s = 1'b0; ready_f = 1'b0;
        wait_cycles(3);
        check("rst_valid", {31'd0, valid_s}, 32'd0);
        check("rst_data",  {24'd0, data_s},  32'd0);
        check("rst_busy",  {31'd0, busy_s},  32'd0);
        check("rst_errs",  {30'd0, ferr_s, ovr_s}, 32'd0);
        rst = 1'b0;
        wait_cycles(4);

        // Byte held with ready low, then a one-cycle accept
        q_s.push_back(8'hA5);
        send(1'b0, 8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_valid", {31'd0, valid_s}, 32'd1);
        check("a5_data",  {24'd0, data_s},  32'h A5);
        check("a5_busy",  {31'd0, busy_s},  32'd0);
        wait_cycles(20);
        check("a5_hold_valid", {31'd0, valid_s}, 32'd1);
        check("a5_hold_data",  {24'd0, data_s},  32'h A5);
        ready_s = 1'b1;
        wait_cycles(1);
        ready_s = 1'b0;
        check("a5_cleared", {31'd0, valid_s}, 32'd0);
        wait_cycles(5);

        // Short low glitch is rejected at the half-bit recheck
        rxd_s = 1'b0;
        wait_cycles(4);
        rxd_s = 1'b1;
        wait_cycles(12);
        check("glitch_busy",  {31'd0, busy_s},  32'd0);
        check("glitch_valid", {31'd0, valid_s}, 32'd0);
        check("glitch_ferr",  fe_s, 32'd0);

        // Bad stop bit followed by a held-low break: one frame error only
        send(1'b0, 8'h3C, 1'b0);
        wait_cycles(40);
        check("break_busy", {31'd0, busy_s}, 32'd1);
        rxd_s = 1'b1;
        wait_cycles(6);
        check("break_ferr",  fe_s, 32'd1);
        check("break_valid", {31'd0, valid_s}, 32'd0);
        check("break_idle",  {31'd0, busy_s},  32'd0);
        q_s.push_back(8'h81);
        send(1'b0, 8'h81, 1'b1);
        wait_cycles(4);
        check("x81_data", {24'd0, data_s}, 32'h81);
        ready_s = 1'b1;
        wait_cycles(1);
        ready_s = 1'b0;
        wait_cycles(4);

        // Back-to-back with ready low: second byte overruns
        q_s.push_back(8'h11);
        send(1'b0, 8'h11, 1'b1);
        send(1'b0, 8'h22, 1'b1);
        wait_cycles(4);
        check("ovr_data",  {24'd0, data_s},  32'h11);
        check("ovr_valid", {31'd0, valid_s}, 32'd1);
        check("ovr_count", ov_s, 32'd1);
        ready_s = 1'b1;
        wait_cycles(1);
        ready_s = 1'b0;
        wait_cycles(4);

        // Back-to-back with ready held high: both delivered, no overrun
        r0 = rise_s;
        ready_s = 1'b1;
        q_s.push_back(8'h11);
        q_s.push_back(8'h22);
        send(1'b0, 8'h11, 1'b1);
        send(1'b0, 8'h22, 1'b1);
        wait_cycles(4);
        check("b2b_rises", rise_s - r0, 32'd2);
        check("b2b_ovr",   ov_s, 32'd1);
        check("b2b_drain", q_s.size(), 32'd0);
        ready_s = 1'b0;
        wait_cycles(4);

        // Reset in the middle of data bit 4 abandons the frame silently
        rxd_s = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 4; i++) begin
            rxd_s = i[0];
            wait_cycles(16);
        end
        rxd_s = 1'b1;
        wait_cycles(8);
        check("mid_busy", {31'd0, busy_s}, 32'd1);
        rst = 1'b1;
        wait_cycles(1);
        check("mrst_valid", {31'd0, valid_s}, 32'd0);
        check("mrst_data",  {24'd0, data_s},  32'd0);
        check("mrst_busy",  {31'd0, busy_s},  32'd0);
        check("mrst_errs",  {30'd0, ferr_s, ovr_s}, 32'd0);
        rst = 1'b0;
        wait_cycles(20);
        check("mrst_no_ferr", fe_s, 32'd1);
        ready_s = 1'b1;
        q_s.push_back(8'hFF);
        send(1'b0, 8'hFF, 1'b1);
        wait_cycles(4);
        ready_s = 1'b0;
        check("ff_drain", q_s.size(), 32'd0);

        // Minimum divisor: two frames back-to-back at 4 clocks per bit
        ready_f = 1'b1;
        q_f.push_back(8'h00);
        q_f.push_back(8'hFF);
        send(1'b1, 8'h00, 1'b1);
        send(1'b1, 8'hFF, 1'b1);
        wait_cycles(4);
        ready_f = 1'b0;
        check("fast_count", used_f, 32'd2);
        check("fast_drain", q_f.size(), 32'd0);
        check("fast_errs",  {30'd0, ferr_f, ovr_f}, 32'd0);

        check("slow_total", used_s, 32'd6);
        check("ferr_total", fe_s, 32'd1);
        check("ovr_total",  ov_s, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
